ir_nec_tx: RTL and testbench

- NEC-protocol infrared transmitter. It is the send-side counterpart of the IR receive path (ir_sniffer): the same 8-bit codes decoded there can be emitted from the board.
- Takes an address/command pair and a start strobe. Produces the NEC frame envelope and a 38 kHz-modulated LED drive.
- Also supports the NEC repeat code.
- Sits beside the receiver in the top level. Driven by keypad/LCD control logic or a loopback test harness.

---
 rtl/ir_nec_pkg.sv | 34 +++
 rtl/ir_carrier_gen.sv | 42 ++++
 rtl/ir_nec_tx.sv | 153 +++++++++++++++
 tb/tb_ir_nec_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// ----------------------------------------------------------------------------
// ir_nec_pkg : shared state encoding and NEC segment lengths for ir_nec_tx
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_REP_SPACE  = 3'd3,
    S_BIT_MARK   = 3'd4,
    S_BIT_SPACE  = 3'd5,
    S_STOP_MARK  = 3'd6,
    S_GAP        = 3'd7
  } nec_state_t;

  // Segment lengths in NEC units T
  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int BIT_U        = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int NEC_BITS     = 32;

  function automatic logic is_mark(input nec_state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_carrier_gen.sv
// ----------------------------------------------------------------------------
// ir_carrier_gen : free-running carrier divider, phase-resettable by sync_clr
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316,
  parameter int CARRIER_HI  = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  output logic carrier
);

  localparam int CNT_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (sync_clr || (cnt_q == CNT_W'(CARRIER_DIV - 1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Level for the coming cycle, so the consumer can register it in phase
  assign carrier = (int'(cnt_d) < CARRIER_HI);

endmodule

`default_nettype wire

// File: rtl/ir_nec_tx.sv
// ----------------------------------------------------------------------------
// ir_nec_tx : NEC infrared transmitter (full frame and repeat code), 38 kHz
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYC    = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int CARRIER_HI  = 439,
  parameter int GAP_UNITS   = 72,
  parameter bit MOD_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       irda_txd,
  output logic       ir_envelope,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int UNIT_W  = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int SEG_MAX = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
  localparam int BIT_W   = $clog2(NEC_BITS);

  nec_state_t              state_q, state_d;
  logic [UNIT_W-1:0]       unit_q, unit_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [NEC_BITS-1:0]     shreg_q, shreg_d;
  logic                    rep_q, rep_d;
  logic                    env_q, busy_q, done_q, txd_q;
  logic                    done_d;
  logic                    unit_end, seg_end, mark_d, sync_clr, carrier;
  int                      seg_len;

  always_comb begin
    seg_len = BIT_U;
    case (state_q)
      S_LEAD_MARK:  seg_len = LEAD_MARK_U;
      S_LEAD_SPACE: seg_len = LEAD_SPACE_U;
      S_REP_SPACE:  seg_len = REP_SPACE_U;
      S_BIT_SPACE:  seg_len = shreg_q[0] ? ONE_SPACE_U : BIT_U;
      S_GAP:        seg_len = GAP_UNITS;
      default:      seg_len = BIT_U;
    endcase
  end

  assign unit_end = (unit_q == UNIT_W'(UNIT_CYC - 1));
  assign seg_end  = unit_end && (seg_q == SEG_W'(seg_len - 1));

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    seg_d   = seg_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      // tx_start has priority when both requests arrive together
      if (tx_start) begin
        state_d = S_LEAD_MARK;
        rep_d   = 1'b0;
        shreg_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
      end else if (tx_repeat) begin
        state_d = S_LEAD_MARK;
        rep_d   = 1'b1;
      end
    end else begin
      unit_d = unit_end ? '0 : unit_q + UNIT_W'(1);
      if (seg_end) begin
        seg_d = '0;
      end else if (unit_end) begin
        seg_d = seg_q + SEG_W'(1);
      end
      if (seg_end) begin
        case (state_q)
          S_LEAD_MARK:  state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = S_BIT_MARK;
          S_REP_SPACE:  state_d = S_STOP_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            shreg_d = {1'b0, shreg_q[NEC_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            state_d = (bit_q == BIT_W'(NEC_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_STOP_MARK:  state_d = S_GAP;
          S_GAP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:      state_d = S_IDLE;
        endcase
      end
    end
  end

  assign mark_d   = is_mark(state_d);
  // Restart the carrier phase so every mark begins with a high carrier cycle
  assign sync_clr = mark_d && (state_d != state_q);

  ir_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HI  (CARRIER_HI)
  ) u_carrier (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .carrier  (carrier)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      seg_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rep_q   <= 1'b0;
      env_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      seg_q   <= seg_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rep_q   <= rep_d;
      env_q   <= mark_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      txd_q   <= MOD_EN ? (mark_d & carrier) : mark_d;
    end
  end

  assign irda_txd    = txd_q;
  assign ir_envelope = env_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_nec_tx.sv
// ----------------------------------------------------------------------------
// tb_ir_nec_tx : directed self-checking bench for ir_nec_tx (short sim timing)
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ir_nec_tx;

  localparam int UNIT = 4;
  localparam int DIV  = 3;
  localparam int HI   = 1;
  localparam int GAPU = 2;
  localparam int CAP  = 600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic       tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       txd1, env1, busy1, done1;
  logic       txd0, env0, busy0, done0;

  always #5 clk = ~clk;

  ir_nec_tx #(.UNIT_CYC(UNIT), .CARRIER_DIV(DIV), .CARRIER_HI(HI),
              .GAP_UNITS(GAPU), .MOD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .irda_txd(txd1), .ir_envelope(env1),
    .tx_busy(busy1), .tx_done(done1));

  ir_nec_tx #(.UNIT_CYC(UNIT), .CARRIER_DIV(DIV), .CARRIER_HI(HI),
              .GAP_UNITS(GAPU), .MOD_EN(1'b0)) u_dut_nomod (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .irda_txd(txd0), .ir_envelope(env0),
    .tx_busy(busy0), .tx_done(done0));

  int   vectors = 0;
  int   miscompares = 0;
  logic c_env [CAP];
  logic c_busy[CAP];
  logic c_done[CAP];
  logic c_txd [CAP];
  logic c_txd0[CAP];
  logic c_env0[CAP];

  // All stimulus and sampling happens 1 ns after a rising edge.
  task automatic send(input logic s, input logic r, input logic [7:0] a, input logic [7:0] c);
    tx_start = s; tx_repeat = r; tx_addr = a; tx_cmd = c;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  task automatic capture(input int n, input int inj);
    for (int i = 0; i < n; i++) begin
      c_env[i] = env1; c_busy[i] = busy1; c_done[i] = done1;
      c_txd[i] = txd1; c_txd0[i] = txd0;  c_env0[i] = env0;
      tx_start = (i == inj);
      @(posedge clk); #1;
    end
    tx_start = 1'b0;
  endtask

  function automatic int count_env(input int lo, input int hi, input logic v);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (c_env[i] === v) n++;
    return n;
  endfunction

  function automatic int count_busy(input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) if (c_busy[i] === 1'b1) k++;
    return k;
  endfunction

  function automatic int count_done(input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) if (c_done[i] === 1'b1) k++;
    return k;
  endfunction

  // Carrier expectation: 1,0,0 repeating from the first cycle of each mark, 0 in spaces.
  function automatic int mod_errors(input int n);
    int   err, run;
    logic e;
    err = 0; run = 0;
    for (int i = 0; i < n; i++) begin
      if (c_env[i] === 1'b1) begin
        e = ((run % 3) == 0);
        run++;
      end else begin
        e = 1'b0;
        run = 0;
      end
      if (c_txd[i] !== e) err++;
    end
    return err;
  endfunction

  function automatic int nomod_errors(input int n);
    int err;
    err = 0;
    for (int i = 0; i < n; i++)
      if (c_txd0[i] !== c_env0[i] || c_env0[i] !== c_env[i]) err++;
    return err;
  endfunction

  // Pulse-distance decode of the captured envelope; bit 32 = well-formed flag.
  function automatic logic [32:0] decode(input int start);
    int          p, m, s;
    logic [31:0] w;
    logic        ok;
    p = start; w = '0; ok = 1'b1;
    for (int b = 0; b < 32; b++) begin
      m = 0; while (p < CAP && c_env[p] === 1'b1) begin m++; p++; end
      s = 0; while (p < CAP && c_env[p] === 1'b0) begin s++; p++; end
      if (m != UNIT) ok = 1'b0;
      if (s == 3 * UNIT) w[b] = 1'b1;
      else if (s != UNIT) ok = 1'b0;
    end
    m = 0; while (p < CAP && c_env[p] === 1'b1) begin m++; p++; end
    if (m != UNIT) ok = 1'b0;
    return {ok, w};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({txd1, env1, busy1, done1, txd0, env0, busy0, done0} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {txd1, env1, busy1, done1, txd0, env0, busy0, done0});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({txd1, env1, busy1, done1} !== 4'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 0000", {txd1, env1, busy1, done1});
    end
  endtask

  task automatic test_full_frame(input string tag, input logic r, input logic [7:0] a,
                                 input logic [7:0] c, input logic [31:0] exp_w, input int inj);
    logic [32:0] d;
    send(1'b1, r, a, c);
    capture(500, inj);
    vectors++;
    if (count_env(0, 63, 1'b1) != 64) begin
      miscompares++;
      $display("FAIL %s lead_mark: got %0d mark cycles expected 64", tag, count_env(0, 63, 1'b1));
    end
    vectors++;
    if (count_env(64, 95, 1'b0) != 32 || c_env[96] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s lead_space: got %0d space cycles, next=%b expected 32, next=1",
               tag, count_env(64, 95, 1'b0), c_env[96]);
    end
    d = decode(96);
    vectors++;
    if (d !== {1'b1, exp_w}) begin
      miscompares++;
      $display("FAIL %s payload: got ok=%b word=%h expected ok=1 word=%h", tag, d[32], d[31:0], exp_w);
    end
    vectors++;
    if (count_env(484, 499, 1'b1) != 0 || c_env[483] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_end: got last_mark=%b trailing_marks=%0d expected 1,0",
               tag, c_env[483], count_env(484, 499, 1'b1));
    end
    vectors++;
    if (count_busy(500) != 492 || c_busy[491] !== 1'b1 || c_busy[492] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_len: got %0d cycles expected 492", tag, count_busy(500));
    end
    vectors++;
    if (count_done(500) != 1 || c_done[492] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_pulse: got count=%0d at492=%b expected count=1 at492=1",
               tag, count_done(500), c_done[492]);
    end
    vectors++;
    if (mod_errors(500) != 0) begin
      miscompares++;
      $display("FAIL %s carrier: got %0d bad cycles expected 0", tag, mod_errors(500));
    end
    vectors++;
    if (nomod_errors(500) != 0) begin
      miscompares++;
      $display("FAIL %s unmodulated: got %0d bad cycles expected 0", tag, nomod_errors(500));
    end
  endtask

  task automatic test_repeat();
    send(1'b0, 1'b1, 8'h00, 8'h00);
    capture(100, -1);
    vectors++;
    if (count_env(0, 63, 1'b1) != 64 || count_env(64, 79, 1'b0) != 16) begin
      miscompares++;
      $display("FAIL rep_lead: got mark=%0d space=%0d expected 64,16",
               count_env(0, 63, 1'b1), count_env(64, 79, 1'b0));
    end
    vectors++;
    if (count_env(80, 83, 1'b1) != 4 || count_env(84, 99, 1'b0) != 16) begin
      miscompares++;
      $display("FAIL rep_stop_gap: got mark=%0d space=%0d expected 4,16",
               count_env(80, 83, 1'b1), count_env(84, 99, 1'b0));
    end
    vectors++;
    if (count_busy(100) != 92 || c_busy[92] !== 1'b0) begin
      miscompares++;
      $display("FAIL rep_busy_len: got %0d cycles expected 92", count_busy(100));
    end
    vectors++;
    if (count_done(100) != 1 || c_done[92] !== 1'b1) begin
      miscompares++;
      $display("FAIL rep_done: got count=%0d at92=%b expected 1,1", count_done(100), c_done[92]);
    end
    vectors++;
    if (mod_errors(100) != 0 || nomod_errors(100) != 0) begin
      miscompares++;
      $display("FAIL rep_txd: got %0d/%0d bad cycles expected 0/0", mod_errors(100), nomod_errors(100));
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    send(1'b1, 1'b0, 8'h55, 8'hAA);
    capture(200, -1);
    vectors++;
    if (env1 !== 1'b1 || txd1 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_precondition: got env=%b txd=%b expected 1,1", env1, txd1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd1, env1, busy1, done1, env0, busy0} !== 6'h00) begin
      miscompares++;
      $display("FAIL abort_async_clear: got %b expected 000000", {txd1, env1, busy1, done1, env0, busy0});
    end
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || done0 === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || done0 === 1'b1 || busy1 === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
    end
    test_full_frame("after_reset", 1'b0, 8'h12, 8'h34, 32'hCB34ED12, -1);
  endtask

  task automatic test_back_to_back();
    int waited;
    send(1'b0, 1'b1, 8'h00, 8'h00);
    waited = 0;
    while (done1 !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_wait: got done=%b busy=%b after %0d cycles expected 1,0",
               done1, busy1, waited);
    end
    test_full_frame("back_to_back", 1'b0, 8'h00, 8'h45, 32'hBA45FF00, -1);
  endtask

  initial begin
    test_reset();
    test_full_frame("frame_00_45", 1'b0, 8'h00, 8'h45, 32'hBA45FF00, -1);
    test_repeat();
    test_full_frame("start_and_repeat", 1'b1, 8'hA5, 8'h3C, 32'hC33C5AA5, 100);
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
